// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A-B one bit per cycle, LSB first, and
// registers the difference plus borrow/zero/overflow flags on completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] DIFF,
    output logic             B_OUT,
    output logic             ZERO,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        d_bit     = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_shift = {d_bit, res_q[WIDTH-1:1]};

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    // Operand MSBs are kept aside since the shift registers lose them.
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    state_d = StFin;
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    zero_d  = (res_shift == '0);
                    ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign DIFF  = diff_q;
    assign B_OUT = bout_q;
    assign ZERO  = zero_q;
    assign OVF   = ovf_q;
    assign BUSY  = (state_q == StShift);
    assign DONE  = (state_q == StFin);

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;
    localparam int Limit = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         b_out;
    logic         zero;
    logic         ovf;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_err;

    serial_subtractor #(
        .WIDTH(W)
    ) u_dut (
        .CLK  (clk),
        .RST  (rst),
        .START(start),
        .A    (a),
        .B    (b),
        .DIFF (diff),
        .B_OUT(b_out),
        .ZERO (zero),
        .OVF  (ovf),
        .BUSY (busy),
        .DONE (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        int ua, ub, sa, sb, sd, ud;
        logic m_ovf, m_zero, m_bout;
        ua = int'(ma);
        ub = int'(mb);
        ud = (ua - ub + (1 << W)) % (1 << W);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        sd = sa - sb;
        m_ovf  = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        m_zero = (ud == 0);
        m_bout = (ua < ub);
        return {m_ovf, m_zero, m_bout, W'(ud)};
    endfunction

    task automatic check_result(input logic [W-1:0] ea, input logic [W-1:0] eb);
        logic [W+2:0] m;
        m = model(ea, eb);
        check("diff", 32'(diff), 32'(m[W-1:0]));
        check("b_out", 32'(b_out), 32'(m[W]));
        check("zero", 32'(zero), 32'(m[W+1]));
        check("ovf", 32'(ovf), 32'(m[W+2]));
    endtask

    // Caller is at a negedge with the DUT idle. Ends at the negedge after FIN.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit poke);
        int n;
        int extra;
        logic [W-1:0] prev;
        prev  = diff;
        start = 1'b1;
        a     = oa;
        b     = ob;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        n     = 0;
        while (!done && n < Limit) begin
            check("busy_in_shift", 32'(busy), 32'd1);
            check("diff_hold", 32'(diff), 32'(prev));
            if (poke && n == 3) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            if (poke && n == 4) start = 1'b0;
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("busy_with_done", 32'(busy), 32'd0);
        check_result(oa, ob);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        if (poke) begin
            extra = 0;
            for (int i = 0; i < W + 4; i++) begin
                if (done || busy) extra++;
                @(negedge clk);
            end
            check("no_second_op", 32'(extra), 32'd0);
            check_result(oa, ob);
        end
    endtask

    initial begin
        int n;
        int extra;
        int cyc;
        int nd;
        int overlap;
        int t_done[3];
        logic [W-1:0] ha;
        logic [W-1:0] hb;

        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h11;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_bout", 32'(b_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // START already high as reset drops: accepted on the first free edge.
        rst = 1'b0;
        do_op(8'h35, 8'h12, 1'b0);
        check("d35_12", 32'(diff), 32'h23);
        do_op(8'h10, 8'h20, 1'b0);
        check("d10_20", 32'(diff), 32'hF0);
        check("d10_20_bout", 32'(b_out), 32'd1);
        do_op(8'h80, 8'h01, 1'b0);
        check("d80_01_ovf", 32'(ovf), 32'd1);
        do_op(8'h55, 8'h55, 1'b0);
        check("d55_55_zero", 32'(zero), 32'd1);
        do_op(8'h00, 8'hFF, 1'b0);
        do_op(8'hFF, 8'h00, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0);
        do_op(8'h7F, 8'h80, 1'b0);

        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), 1'b0);
        end

        do_op(8'h35, 8'h12, 1'b1);

        // Abort mid-operation with reset.
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        rst   = 1'b0;
        extra = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);
        do_op(8'h35, 8'h12, 1'b0);
        check("after_abort", 32'(diff), 32'h23);

        // START held high: three back-to-back operations.
        ha      = W'($urandom);
        hb      = W'($urandom);
        start   = 1'b1;
        a       = ha;
        b       = hb;
        cyc     = 0;
        nd      = 0;
        overlap = 0;
        while (nd < 3 && cyc < 3 * Limit) begin
            @(negedge clk);
            cyc++;
            if (busy && done) overlap++;
            if (done) begin
                t_done[nd] = cyc;
                nd++;
                check_result(ha, hb);
                if (nd == 3) start = 1'b0;
            end
        end
        check("b2b_count", 32'(nd), 32'd3);
        check("b2b_overlap", 32'(overlap), 32'd0);
        if (nd == 3) begin
            check("b2b_gap1", 32'(t_done[1] - t_done[0]), 32'(W + 2));
            check("b2b_gap2", 32'(t_done[2] - t_done[1]), 32'(W + 2));
        end
        repeat (3) @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
